id_ex_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the EX-stage ALU (logic/arith units). Registers decoded operands and control each cycle, resolves EX/MEM and MEM/WB data forwarding onto the ALU operand buses, detects load-use hazards and inserts bubbles, and honours branch flushes. Its `ex_op_a`/`ex_op_b`/`ex_opsel` outputs drive the ALU operand and `log_opsel` inputs.

---
 rtl/id_ex_stage_pkg.sv | 15 +
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage_fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and ALU sub-op encodings for the ID/EX stage and its forwarding muxes.
package id_ex_stage_pkg;

  localparam int REG_WIDTH = 32;
  localparam int RADDR_W   = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_NOR = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side, forwarding and EX-side signals of the ID/EX stage bundled as one bus.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                 id_valid;
  logic [RADDR_W-1:0]   id_rs;
  logic [RADDR_W-1:0]   id_rt;
  logic [RADDR_W-1:0]   id_rd;
  logic [REG_WIDTH-1:0] id_rs_data;
  logic [REG_WIDTH-1:0] id_rt_data;
  logic [REG_WIDTH-1:0] id_imm;
  logic                 id_use_imm;
  logic [2:0]           id_opsel;
  logic                 id_reg_write;
  logic                 id_mem_read;
  logic                 flush;

  logic                 exmem_reg_write;
  logic [RADDR_W-1:0]   exmem_rd;
  logic [REG_WIDTH-1:0] exmem_result;
  logic                 memwb_reg_write;
  logic [RADDR_W-1:0]   memwb_rd;
  logic [REG_WIDTH-1:0] memwb_data;

  logic                 hazard_stall;
  logic                 ex_valid;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic [RADDR_W-1:0]   ex_rd;
  logic [2:0]           ex_opsel;
  logic [REG_WIDTH-1:0] ex_op_a;
  logic [REG_WIDTH-1:0] ex_op_b;
  logic [REG_WIDTH-1:0] ex_store_data;
  logic [15:0]          stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_opsel, id_reg_write, id_mem_read, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_opsel,
           ex_op_a, ex_op_b, ex_store_data, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_use_imm, id_opsel, id_reg_write, id_mem_read, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_opsel,
           ex_op_a, ex_op_b, ex_store_data, stall_count
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass: picks EX/MEM, then MEM/WB, then register-file data for one source index.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [RADDR_W-1:0]   src,
  input  logic [REG_WIDTH-1:0] reg_data,
  input  logic                 exmem_reg_write,
  input  logic [RADDR_W-1:0]   exmem_rd,
  input  logic [REG_WIDTH-1:0] exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [RADDR_W-1:0]   memwb_rd,
  input  logic [REG_WIDTH-1:0] memwb_data,
  output logic [REG_WIDTH-1:0] fwd_data
);

  // r0 is hardwired, so a write to it must never shadow the register-file value
  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd == src) && (src != '0)) begin
      fwd_data = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == src) && (src != '0)) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic                 vld_p1;
  logic                 rw_p1;
  logic                 mr_p1;
  logic [RADDR_W-1:0]   rd_p1;
  logic [RADDR_W-1:0]   rs_p1;
  logic [RADDR_W-1:0]   rt_p1;
  logic [REG_WIDTH-1:0] rs_data_p1;
  logic [REG_WIDTH-1:0] rt_data_p1;
  logic [REG_WIDTH-1:0] imm_p1;
  logic                 use_imm_p1;
  alu_op_e              opsel_p1;
  logic [15:0]          stall_cnt_p1;

  logic                 load_use;
  logic                 stall;
  logic [REG_WIDTH-1:0] rs_fwd;
  logic [REG_WIDTH-1:0] rt_fwd;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use = vld_p1 & mr_p1 & (rd_p1 != '0) & bus.id_valid &
                    ((rd_p1 == bus.id_rs) | (!bus.id_use_imm & (rd_p1 == bus.id_rt)));
  assign stall    = load_use & !bus.flush;

  // ID -> EX boundary; a bubble clears control only and leaves the data fields as they were
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      rw_p1        <= 1'b0;
      mr_p1        <= 1'b0;
      rd_p1        <= '0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      imm_p1       <= '0;
      use_imm_p1   <= 1'b0;
      opsel_p1     <= ALU_AND;
      stall_cnt_p1 <= '0;
    end else begin
      if (bus.flush || load_use) begin
        vld_p1 <= 1'b0;
        rw_p1  <= 1'b0;
        mr_p1  <= 1'b0;
      end else begin
        vld_p1     <= bus.id_valid;
        rw_p1      <= bus.id_reg_write;
        mr_p1      <= bus.id_mem_read;
        rd_p1      <= bus.id_rd;
        rs_p1      <= bus.id_rs;
        rt_p1      <= bus.id_rt;
        rs_data_p1 <= bus.id_rs_data;
        rt_data_p1 <= bus.id_rt_data;
        imm_p1     <= bus.id_imm;
        use_imm_p1 <= bus.id_use_imm;
        opsel_p1   <= alu_op_e'(bus.id_opsel);
      end
      if (stall) begin
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      end
    end
  end

  fwd_mux u_fwd_rs (
    .src             (rs_p1),
    .reg_data        (rs_data_p1),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_data      (bus.memwb_data),
    .fwd_data        (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src             (rt_p1),
    .reg_data        (rt_data_p1),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_data      (bus.memwb_data),
    .fwd_data        (rt_fwd)
  );

  assign bus.hazard_stall  = stall;
  assign bus.ex_valid      = vld_p1;
  assign bus.ex_reg_write  = rw_p1;
  assign bus.ex_mem_read   = mr_p1;
  assign bus.ex_rd         = rd_p1;
  assign bus.ex_opsel      = opsel_p1;
  assign bus.ex_op_a       = rs_fwd;
  assign bus.ex_op_b       = use_imm_p1 ? imm_p1 : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.stall_count   = stall_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reset, table of ID/forwarding vectors through a scoreboard, reset mid-stall.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct {
    logic vld; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm;
    logic ui; logic [2:0] op; logic rw, mr, fl;
  } id_t;

  typedef struct {
    logic xwe; logic [4:0] xrd; logic [31:0] xres;
    logic wwe; logic [4:0] wrd; logic [31:0] wdat;
  } fw_t;

  typedef struct {
    logic stall, vld, rw, mr, dat; logic [4:0] rd; logic [2:0] op;
    logic [31:0] a, b, sd; logic [15:0] cnt;
  } ex_t;

  typedef struct { id_t id; fw_t fw; ex_t ex; } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[15];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic id_t idv(int vld, int rs, int rt, int rd, int rsd, int rtd, int imm,
                              int ui, int op, int rw, int mr, int fl);
    id_t t;
    t.vld = 1'(vld); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.rsd = 32'(rsd); t.rtd = 32'(rtd); t.imm = 32'(imm);
    t.ui = 1'(ui); t.op = 3'(op); t.rw = 1'(rw); t.mr = 1'(mr); t.fl = 1'(fl);
    return t;
  endfunction

  function automatic fw_t fwv(int xwe, int xrd, int xres, int wwe, int wrd, int wdat);
    fw_t t;
    t.xwe = 1'(xwe); t.xrd = 5'(xrd); t.xres = 32'(xres);
    t.wwe = 1'(wwe); t.wrd = 5'(wrd); t.wdat = 32'(wdat);
    return t;
  endfunction

  function automatic ex_t exv(int stall, int vld, int rw, int mr, int dat, int rd, int op,
                              int a, int b, int sd, int cnt);
    ex_t t;
    t.stall = 1'(stall); t.vld = 1'(vld); t.rw = 1'(rw); t.mr = 1'(mr); t.dat = 1'(dat);
    t.rd = 5'(rd); t.op = 3'(op); t.a = 32'(a); t.b = 32'(b); t.sd = 32'(sd); t.cnt = 16'(cnt);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_id(input id_t t);
    bus.id_valid = t.vld; bus.id_rs = t.rs; bus.id_rt = t.rt; bus.id_rd = t.rd;
    bus.id_rs_data = t.rsd; bus.id_rt_data = t.rtd; bus.id_imm = t.imm;
    bus.id_use_imm = t.ui; bus.id_opsel = t.op; bus.id_reg_write = t.rw;
    bus.id_mem_read = t.mr; bus.flush = t.fl;
  endtask

  task automatic drive_fw(input fw_t t);
    bus.exmem_reg_write = t.xwe; bus.exmem_rd = t.xrd; bus.exmem_result = t.xres;
    bus.memwb_reg_write = t.wwe; bus.memwb_rd = t.wrd; bus.memwb_data = t.wdat;
  endtask

  task automatic drive_random();
    bus.id_valid = 1'($urandom); bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
    bus.id_rd = 5'($urandom); bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
    bus.id_imm = $urandom; bus.id_use_imm = 1'($urandom); bus.id_opsel = 3'($urandom);
    bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom); bus.flush = 1'($urandom);
    bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom); bus.exmem_result = $urandom;
    bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom); bus.memwb_data = $urandom;
  endtask

  // ID applied mid-cycle; forwarding ports describe the later stages after the edge
  task automatic run_vec(input int idx, input vec_t t);
    vec_t e;
    @(negedge clk);
    drive_id(t.id);
    #1;
    exp_q.push_back(t);
    check($sformatf("v%0d hazard_stall", idx), 32'(bus.hazard_stall), 32'(t.ex.stall));
    @(posedge clk);
    #1;
    drive_fw(t.fw);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d ex_valid", idx), 32'(bus.ex_valid), 32'(e.ex.vld));
      check($sformatf("v%0d ex_reg_write", idx), 32'(bus.ex_reg_write), 32'(e.ex.rw));
      check($sformatf("v%0d ex_mem_read", idx), 32'(bus.ex_mem_read), 32'(e.ex.mr));
      check($sformatf("v%0d stall_count", idx), 32'(bus.stall_count), 32'(e.ex.cnt));
      if (e.ex.dat) begin
        check($sformatf("v%0d ex_rd", idx), 32'(bus.ex_rd), 32'(e.ex.rd));
        check($sformatf("v%0d ex_opsel", idx), 32'(bus.ex_opsel), 32'(e.ex.op));
        check($sformatf("v%0d ex_op_a", idx), bus.ex_op_a, e.ex.a);
        check($sformatf("v%0d ex_op_b", idx), bus.ex_op_b, e.ex.b);
        check($sformatf("v%0d ex_store_data", idx), bus.ex_store_data, e.ex.sd);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
    check({tag, " ex_reg_write"}, 32'(bus.ex_reg_write), 32'd0);
    check({tag, " ex_mem_read"}, 32'(bus.ex_mem_read), 32'd0);
    check({tag, " ex_rd"}, 32'(bus.ex_rd), 32'd0);
    check({tag, " ex_opsel"}, 32'(bus.ex_opsel), 32'd0);
    check({tag, " ex_op_a"}, bus.ex_op_a, 32'd0);
    check({tag, " ex_op_b"}, bus.ex_op_b, 32'd0);
    check({tag, " ex_store_data"}, bus.ex_store_data, 32'd0);
    check({tag, " stall_count"}, 32'(bus.stall_count), 32'd0);
    check({tag, " hazard_stall"}, 32'(bus.hazard_stall), 32'd0);
  endtask

  initial begin
    fw_t nofw;
    nofw = fwv(0, 0, 0, 0, 0, 0);

    tbl[0]  = '{idv(1, 3, 4, 8, 'h1, 'h2, 0, 0, ALU_OR, 1, 0, 0),
                fwv(1, 3, 'hF0, 0, 0, 0),
                exv(0, 1, 1, 0, 1, 8, ALU_OR, 'hF0, 'h2, 'h2, 0)};
    tbl[1]  = '{idv(1, 5, 5, 9, 'h11, 'h22, 0, 0, ALU_AND, 1, 0, 0),
                fwv(1, 5, 'hAA, 1, 5, 'hBB),
                exv(0, 1, 1, 0, 1, 9, ALU_AND, 'hAA, 'hAA, 'hAA, 0)};
    tbl[2]  = '{idv(1, 0, 0, 10, 'h33, 'h44, 0, 0, ALU_XOR, 1, 0, 0),
                fwv(1, 0, 'hAA, 1, 0, 'hBB),
                exv(0, 1, 1, 0, 1, 10, ALU_XOR, 'h33, 'h44, 'h44, 0)};
    tbl[3]  = '{idv(1, 6, 2, 11, 'h1, 'h2, 0, 0, ALU_NOR, 1, 0, 0),
                fwv(0, 6, 'hCC, 1, 2, 'hDD),
                exv(0, 1, 1, 0, 1, 11, ALU_NOR, 'h1, 'hDD, 'hDD, 0)};
    tbl[4]  = '{idv(1, 1, 0, 7, 'h100, 'h55, 'h4, 1, ALU_AND, 1, 1, 0), nofw,
                exv(0, 1, 1, 1, 1, 7, ALU_AND, 'h100, 'h4, 'h55, 0)};
    tbl[5]  = '{idv(1, 7, 3, 12, 'h77, 'h3, 0, 0, ALU_AND, 1, 0, 0), nofw,
                exv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{idv(1, 7, 3, 12, 'h77, 'h3, 0, 0, ALU_AND, 1, 0, 0),
                fwv(0, 0, 0, 1, 7, 'hDEAD),
                exv(0, 1, 1, 0, 1, 12, ALU_AND, 'hDEAD, 'h3, 'h3, 1)};
    tbl[7]  = '{idv(1, 1, 0, 7, 'h200, 'h0, 'h8, 1, ALU_AND, 1, 1, 0), nofw,
                exv(0, 1, 1, 1, 1, 7, ALU_AND, 'h200, 'h8, 'h0, 1)};
    tbl[8]  = '{idv(1, 2, 7, 13, 'h9, 'h66, 'h1234, 1, ALU_SLT, 1, 0, 0),
                fwv(1, 7, 'hEE, 0, 0, 0),
                exv(0, 1, 1, 0, 1, 13, ALU_SLT, 'h9, 'h1234, 'hEE, 1)};
    tbl[9]  = '{idv(1, 1, 0, 7, 0, 0, 0, 1, ALU_AND, 1, 1, 0), nofw,
                exv(0, 1, 1, 1, 1, 7, ALU_AND, 0, 0, 0, 1)};
    tbl[10] = '{idv(1, 7, 3, 12, 0, 0, 0, 0, ALU_AND, 1, 0, 1), nofw,
                exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{idv(1, 1, 0, 7, 0, 0, 0, 1, ALU_AND, 1, 1, 0), nofw,
                exv(0, 1, 1, 1, 1, 7, ALU_AND, 0, 0, 0, 1)};
    tbl[12] = '{idv(0, 7, 7, 12, 0, 0, 0, 0, ALU_AND, 0, 0, 0), nofw,
                exv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[13] = '{idv(1, 1, 0, 0, 'h1, 0, 0, 1, ALU_AND, 1, 1, 0), nofw,
                exv(0, 1, 1, 1, 1, 0, ALU_AND, 'h1, 0, 0, 1)};
    tbl[14] = '{idv(1, 0, 0, 14, 'h5, 'h6, 0, 0, ALU_AND, 1, 0, 0), nofw,
                exv(0, 1, 1, 0, 1, 14, ALU_AND, 'h5, 'h6, 'h6, 1)};

    rst_n = 1'b0;
    drive_random();
    @(posedge clk);
    @(negedge clk);
    drive_random();
    @(posedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    drive_id(idv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_fw(nofw);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(i, tbl[i]);
    end

    // Load r7 into EX, present a dependent AND, then reset while the stall is pending
    @(negedge clk);
    drive_id(idv(1, 1, 0, 7, 0, 0, 0, 1, ALU_AND, 1, 1, 0));
    @(negedge clk);
    drive_id(idv(1, 7, 3, 12, 'h77, 'h3, 0, 0, ALU_AND, 1, 0, 0));
    #1;
    check("midreset stall before", 32'(bus.hazard_stall), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset ex_valid", 32'(bus.ex_valid), 32'd0);
    check("midreset stall_count", 32'(bus.stall_count), 32'd0);
    check("midreset hazard_stall", 32'(bus.hazard_stall), 32'd0);
    check("midreset ex_op_a", bus.ex_op_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after reset ex_valid", 32'(bus.ex_valid), 32'd1);
    check("after reset ex_op_a", bus.ex_op_a, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
